// File: rtl/fir_mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fir_mac_sequencer
// Purpose  : Sequences a 64-tap FIR multiply-accumulate over external sample
//            and coefficient stores, with Q15 rounding and saturation.
// Revision : 1.0 - initial release
// ============================================================================
module fir_mac_sequencer #(
    parameter int DATA_SIZE = 16,
    parameter int ADDR_SIZE = 6,
    parameter int ACC_SIZE  = 40
) (
    input  logic                 rclk,
    input  logic                 rrst,
    input  logic                 start,
    input  logic [ADDR_SIZE-1:0] head_addr,
    output logic [ADDR_SIZE-1:0] raddr,
    input  logic [DATA_SIZE-1:0] rdata,
    output logic [ADDR_SIZE-1:0] coef_addr,
    input  logic [DATA_SIZE-1:0] coef_data,
    output logic [DATA_SIZE-1:0] out_data,
    output logic                 out_valid,
    output logic                 busy,
    output logic                 overrun
);

    localparam int PROD_SIZE = 2 * DATA_SIZE;
    localparam int SHIFT     = DATA_SIZE - 1;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ACCUM = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;
    localparam logic [1:0] c_ROUND = 2'd3;

    // Half an output LSB, and the output range expressed at accumulator width
    localparam logic signed [ACC_SIZE-1:0] c_ROUND_BIAS =
        {{(ACC_SIZE-DATA_SIZE+1){1'b0}}, 1'b1, {(DATA_SIZE-2){1'b0}}};
    localparam logic signed [ACC_SIZE-1:0] c_SAT_MAX =
        {{(ACC_SIZE-DATA_SIZE+1){1'b0}}, {(DATA_SIZE-1){1'b1}}};
    localparam logic signed [ACC_SIZE-1:0] c_SAT_MIN =
        {{(ACC_SIZE-DATA_SIZE+1){1'b1}}, {(DATA_SIZE-1){1'b0}}};

    logic [1:0]                  r_state;
    logic [ADDR_SIZE-1:0]        r_k;
    logic [ADDR_SIZE-1:0]        r_head;
    logic signed [ACC_SIZE-1:0]  r_acc;
    logic signed [PROD_SIZE-1:0] r_prod;
    logic [DATA_SIZE-1:0]        r_out;
    logic                        r_valid;
    logic                        r_overrun;

    logic signed [PROD_SIZE-1:0] w_prod;
    logic signed [ACC_SIZE-1:0]  w_prod_ext;
    logic signed [ACC_SIZE-1:0]  w_biased;
    logic signed [ACC_SIZE-1:0]  w_shifted;
    logic [DATA_SIZE-1:0]        w_sat;
    logic                        w_idle;

    assign w_idle     = (r_state == c_IDLE);
    assign w_prod     = $signed(rdata) * $signed(coef_data);
    assign w_prod_ext = {{(ACC_SIZE-PROD_SIZE){r_prod[PROD_SIZE-1]}}, r_prod};
    assign w_biased   = r_acc + c_ROUND_BIAS;
    assign w_shifted  = w_biased >>> SHIFT;

    always_comb begin
        w_sat = w_shifted[DATA_SIZE-1:0];
        if (w_shifted > c_SAT_MAX) begin
            w_sat = c_SAT_MAX[DATA_SIZE-1:0];
        end else if (w_shifted < c_SAT_MIN) begin
            w_sat = c_SAT_MIN[DATA_SIZE-1:0];
        end
    end

    // Newest sample sits at head; tap k reads k samples back, wrapping naturally
    assign raddr     = w_idle ? head_addr : (r_head - r_k);
    assign coef_addr = w_idle ? {ADDR_SIZE{1'b0}} : r_k;

    assign out_data  = r_out;
    assign out_valid = r_valid;
    assign busy      = ~w_idle;
    assign overrun   = r_overrun;

    always_ff @(posedge rclk) begin
        if (rrst) begin
            r_state   <= c_IDLE;
            r_k       <= '0;
            r_head    <= '0;
            r_acc     <= '0;
            r_prod    <= '0;
            r_out     <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (start && !w_idle) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_head  <= head_addr;
                        r_k     <= '0;
                        r_acc   <= '0;
                        r_prod  <= '0;
                        r_state <= c_ACCUM;
                    end
                end
                c_ACCUM: begin
                    // Product lags one cycle; the first addition adds the cleared product
                    r_prod <= w_prod;
                    r_acc  <= r_acc + w_prod_ext;
                    r_k    <= r_k + ADDR_SIZE'(1);
                    if (r_k == {ADDR_SIZE{1'b1}}) begin
                        r_state <= c_DRAIN;
                    end
                end
                c_DRAIN: begin
                    r_acc   <= r_acc + w_prod_ext;
                    r_state <= c_ROUND;
                end
                c_ROUND: begin
                    r_out   <= w_sat;
                    r_valid <= 1'b1;
                    r_state <= c_IDLE;
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fir_mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_mac_sequencer
// Purpose  : Self-checking bench for fir_mac_sequencer against a dot-product
//            reference model over behavioural sample/coefficient stores.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fir_mac_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  head_addr = '0;
    logic [5:0]  raddr;
    logic [15:0] rdata;
    logic [5:0]  coef_addr;
    logic [15:0] coef_data;
    logic [15:0] out_data;
    logic        out_valid;
    logic        busy;
    logic        overrun;

    logic [15:0] mem  [64];
    logic [15:0] coef [64];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign rdata     = mem[raddr];
    assign coef_data = coef[coef_addr];

    fir_mac_sequencer #(
        .DATA_SIZE(16),
        .ADDR_SIZE(6),
        .ACC_SIZE (40)
    ) dut (
        .rclk     (clk),
        .rrst     (rst),
        .start    (start),
        .head_addr(head_addr),
        .raddr    (raddr),
        .rdata    (rdata),
        .coef_addr(coef_addr),
        .coef_data(coef_data),
        .out_data (out_data),
        .out_valid(out_valid),
        .busy     (busy),
        .overrun  (overrun)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // y = sat(round(sum_k x[head-k] * c[k] / 2^15))
    function automatic logic [15:0] model(input logic [5:0] h);
        longint acc;
        longint r;
        acc = 0;
        for (int k = 0; k < 64; k++) begin
            acc += longint'($signed(mem[(int'(h) - k) & 63])) * longint'($signed(coef[k]));
        end
        r = (acc + 16384) >>> 15;
        if (r > 32767)  r = 32767;
        if (r < -32768) r = -32768;
        return r[15:0];
    endfunction

    task automatic fill(input logic [15:0] sv, input logic [15:0] cv);
        for (int i = 0; i < 64; i++) begin
            mem[i]  = sv;
            coef[i] = cv;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_request(input string tag, input logic [5:0] h, input logic [15:0] exp);
        int n;
        int nbusy;
        head_addr = h;
        start = 1'b1;
        step();
        start = 1'b0;
        head_addr = 6'($urandom);
        n = 0;
        nbusy = 0;
        while (!out_valid && n < 200) begin
            if (n < 64) begin
                chk({tag, "_raddr"}, 32'((int'(h) - n) & 63), 32'(raddr));
                chk({tag, "_coef_addr"}, 32'(coef_addr), 32'(n));
            end
            if (busy) nbusy++;
            step();
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'd66);
        chk({tag, "_busy_cycles"}, 32'(nbusy), 32'd66);
        chk({tag, "_out_data"}, 32'(out_data), 32'(exp));
        step();
        chk({tag, "_valid_pulse"}, 32'(out_valid), 32'd0);
        step();
        chk({tag, "_hold"}, 32'(out_data), 32'(exp));
    endtask

    task automatic back_to_back();
        logic [5:0]  hq [3];
        logic [15:0] eq [3];
        int n;
        int got;
        int last;
        for (int i = 0; i < 3; i++) begin
            hq[i] = 6'($urandom);
            eq[i] = model(hq[i]);
        end
        head_addr = hq[0];
        start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        got = 0;
        last = 0;
        while (got < 3 && n < 400) begin
            step();
            n++;
            start = 1'b0;
            if (out_valid) begin
                chk("b2b_data", 32'(out_data), 32'(eq[got]));
                chk("b2b_gap", 32'(n - last), (got == 0) ? 32'd66 : 32'd67);
                last = n;
                got++;
                if (got < 3) begin
                    head_addr = hq[got];
                    start = 1'b1;
                end
            end
        end
        chk("b2b_count", 32'(got), 32'd3);
        chk("b2b_overrun", 32'(overrun), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] exp;
        logic [5:0]  h1;
        int          nv;

        fill(16'h0000, 16'h0000);
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        head_addr = 6'd17;
        step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("idle_raddr", 32'(raddr), 32'd17);
        chk("idle_coef_addr", 32'(coef_addr), 32'd0);

        // Single non-zero tap, all samples equal
        fill(16'h4000, 16'h0000);
        coef[0] = 16'h4000;
        do_request("unit", 6'd10, 16'h2000);

        // Address wrap below zero
        fill(16'h0000, 16'h0000);
        mem[63] = 16'h1000;
        coef[3] = 16'h7FFF;
        do_request("wrap", 6'd2, 16'h1000);

        fill(16'h7FFF, 16'h7FFF);
        do_request("sat_pos", 6'($urandom), 16'h7FFF);
        fill(16'h8000, 16'h7FFF);
        do_request("sat_neg", 6'($urandom), 16'h8000);

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 64; i++) begin
                mem[i]  = 16'($urandom);
                coef[i] = (r % 2 == 0) ? 16'($signed(16'($urandom)) >>> 5) : 16'($urandom);
            end
            h1 = 6'($urandom);
            do_request("rand", h1, model(h1));
        end

        back_to_back();

        // Start while busy: ignored, flags overrun
        h1 = 6'($urandom);
        exp = model(h1);
        head_addr = h1;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (19) step();
        head_addr = h1 + 6'd7;
        start = 1'b1;
        step();
        start = 1'b0;
        nv = 0;
        while (!out_valid && nv < 200) begin
            step();
            nv++;
        end
        chk("ovr_latency", 32'(nv + 20), 32'd66);
        chk("ovr_data", 32'(out_data), 32'(exp));
        chk("ovr_flag", 32'(overrun), 32'd1);
        nv = 0;
        for (int i = 0; i < 80; i++) begin
            step();
            if (out_valid) nv++;
        end
        chk("ovr_extra_valid", 32'(nv), 32'd0);
        chk("ovr_sticky", 32'(overrun), 32'd1);

        // Reset mid-accumulation at k=30
        head_addr = 6'($urandom);
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (30) step();
        chk("mid_k", 32'(coef_addr), 32'd30);
        rst = 1'b1;
        head_addr = 6'd33;
        step();
        rst = 1'b0;
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_out_data", 32'(out_data), 32'd0);
        chk("mid_overrun", 32'(overrun), 32'd0);
        chk("mid_raddr", 32'(raddr), 32'd33);
        nv = 0;
        for (int i = 0; i < 80; i++) begin
            if (out_valid) nv++;
            step();
        end
        chk("mid_no_valid", 32'(nv), 32'd0);
        chk("mid_out_data_after", 32'(out_data), 32'd0);

        // Reset wins over a coincident start
        rst = 1'b1;
        start = 1'b1;
        step();
        rst = 1'b0;
        start = 1'b0;
        chk("rst_prio_busy", 32'(busy), 32'd0);

        h1 = 6'($urandom);
        do_request("post_rst", h1, model(h1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fir_mac_sequencer.md
FIR_MAC_SEQUENCER -- requirements
Module: fir_mac_sequencer

Interface
REQ-001 Parameter DATA_SIZE, default 16: width of samples, coefficients and output, signed two's complement Q15.
REQ-002 Parameter ADDR_SIZE, default 6: sample-memory and coefficient address width; TAPS = 1<<ADDR_SIZE = 64.
REQ-003 Parameter ACC_SIZE, default 40: accumulator width.
REQ-004 Clocking and reset: one clock; reset is synchronous and active-high.
REQ-005 rclk  in  1  sole clock; all state updates on its rising edge.
REQ-006 rrst  in  1  synchronous active-high reset.
REQ-007 start  in  1  one-cycle request: the newest sample is stored at head_addr.
REQ-008 head_addr  in  ADDR_SIZE  sample-memory address of the newest sample.
REQ-009 raddr  out  ADDR_SIZE  read address into the sample memory.
REQ-010 rdata  in  DATA_SIZE  sample read data, combinational from raddr in the same cycle.
REQ-011 coef_addr  out  ADDR_SIZE  tap index into the coefficient store.
REQ-012 coef_data  in  DATA_SIZE  coefficient, combinational from coef_addr in the same cycle.
REQ-013 out_data  out  DATA_SIZE  filtered output sample, registered.
REQ-014 out_valid  out  1  one-cycle pulse when out_data is updated.
REQ-015 busy  out  1  high whenever state is not IDLE.
REQ-016 overrun  out  1  sticky flag: start was seen while busy.

Function
REQ-017 FSM states: IDLE, ACCUM, DRAIN, ROUND; the FSM has no other reachable state.
REQ-018 IDLE, edge E0 with start=1: latch head_addr into head_q, clear tap counter k and accumulator, clear product register, go to ACCUM.
REQ-019 ACCUM: raddr = (head_q - k) mod TAPS with natural wrap, coef_addr = k.
REQ-020 ACCUM edges E1..E64: product register <= signed rdata * signed coef_data (2*DATA_SIZE bits), k increments; at k=TAPS-1 go to DRAIN.
REQ-021 Accumulator adds sign-extended product register on edges E2..E65; DRAIN lasts one cycle (E65), then go to ROUND.
REQ-022 ROUND, edge E66: out_data <= saturate((acc + 2^14) >>> 15) to [-32768, 32767]; out_valid=1 for the following cycle only; go to IDLE.
REQ-023 Latency: out_valid is high in the cycle after E66, 66 clocks after the start-sampling edge; the minimum start-to-start spacing is 67 clocks.
REQ-024 A start asserted in the out_valid cycle is accepted, because the FSM is then in IDLE.
REQ-025 A start while busy is ignored and sets overrun; the computation in progress is unaffected, head_q is unchanged, and exactly one out_valid is produced.
REQ-026 In IDLE, raddr = head_addr and coef_addr = 0; the sample and coefficient stores are read-only from this block.
REQ-027 out_data holds its value between out_valid pulses.
REQ-028 The accumulator does not wrap for any input set: 64 * 2^30 fits in ACC_SIZE signed bits.

Reset
REQ-029 rrst=1 at any edge, mid-operation included: state IDLE; k, head_q, accumulator, product register and out_data are 0; out_valid, busy and overrun are 0; any in-flight result is discarded.
REQ-030 rrst has priority over start in the same cycle.

Verification
REQ-031 All samples 0x4000, coef[0]=0x4000, other coefficients 0, head=10, start -> one out_valid 66 clocks later with out_data=0x2000, busy high for 66 cycles.
REQ-032 Wrap: head=2, mem[63]=0x1000, all other samples 0, coef[3]=0x7FFF, others 0 -> raddr sequence 2,1,0,63,62,... and out_data=0x1000.
REQ-033 Saturation: all samples and coefficients 0x7FFF -> out_data=0x7FFF; all samples 0x8000 with all coefficients 0x7FFF -> out_data=0x8000.
REQ-034 Second start 20 cycles after the first -> overrun=1 and stays 1, exactly one out_valid, result equals the first request's expected value.
REQ-035 rrst pulsed in ACCUM at k=30 -> next cycle busy=0, no out_valid ever appears, out_data=0; a new start then yields the correct result.
REQ-036 Start pulsed in each out_valid cycle for 3 requests -> out_valid every 67 clocks, overrun stays 0.
